// File: rtl/out_display.sv
// Output-port peripheral for the SIMPLE CPU: latches OUT values and drives an
// 8-digit multiplexed 7-segment display in hex or signed decimal.
module out_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_we,
    input  logic [15:0] out_data,
    input  logic        dec_mode,
    output logic        busy,
    output logic [15:0] shown_value,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n
);

    // Digit codes: 0..15 are hex glyphs, then blank and minus.
    localparam logic [4:0]       CODE_BLANK = 5'd16;
    localparam logic [4:0]       CODE_MINUS = 5'd17;
    localparam logic [7:0][4:0]  RESET_BUF  = {{7{CODE_BLANK}}, 5'd0};
    localparam logic [15:0]      SCAN_LAST  = 16'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

    function automatic logic [7:0] glyph(input logic [4:0] code);
        logic [7:0] g;
        case (code)
            5'd0:    g = 8'hC0;
            5'd1:    g = 8'hF9;
            5'd2:    g = 8'hA4;
            5'd3:    g = 8'hB0;
            5'd4:    g = 8'h99;
            5'd5:    g = 8'h92;
            5'd6:    g = 8'h82;
            5'd7:    g = 8'hF8;
            5'd8:    g = 8'h80;
            5'd9:    g = 8'h90;
            5'd10:   g = 8'h88;
            5'd11:   g = 8'h83;
            5'd12:   g = 8'hC6;
            5'd13:   g = 8'hA1;
            5'd14:   g = 8'h86;
            5'd15:   g = 8'h8E;
            5'd17:   g = 8'hBF;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
        logic [19:0] r;
        r = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t           state_r;
    logic [3:0]       step_r;
    logic [15:0]      mag_r;
    logic [19:0]      bcd_r;
    logic             neg_r;
    logic [15:0]      pend_value_r;
    logic             busy_r;
    logic [15:0]      shown_r;
    logic [7:0][4:0]  digit_buf_r;
    logic [15:0]      cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       seg_n_r;
    logic [7:0]       an_n_r;

    logic [15:0]      in_mag_s;
    logic [19:0]      bcd_adj_s;
    logic [31:0]      bcd_pad_s;
    logic [2:0]       msd_s;
    logic [7:0][4:0]  hex_buf_s;
    logic [7:0][4:0]  fmt_buf_s;
    logic [7:0][4:0]  buf_next_s;
    logic [15:0]      shown_next_s;
    logic             cnt_wrap_s;
    logic [2:0]       idx_next_s;

    // Magnitude of the incoming value and the adjusted BCD for the next shift.
    always_comb begin
        if (out_data[15]) begin
            in_mag_s = ~out_data + 16'd1;
        end else begin
            in_mag_s = out_data;
        end
        bcd_adj_s = dd_adjust(bcd_r);
    end

    // Glyph codes for hex writes and for the formatted decimal result.
    always_comb begin
        hex_buf_s = {8{CODE_BLANK}};
        for (int i = 0; i < 4; i++) begin
            hex_buf_s[i] = {1'b0, out_data[4*i +: 4]};
        end
        bcd_pad_s = {12'd0, bcd_r};
        msd_s = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd_pad_s[4*i +: 4] != 4'd0) begin
                msd_s = 3'(i);
            end else begin
                msd_s = msd_s;
            end
        end
        fmt_buf_s = {8{CODE_BLANK}};
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= msd_s) begin
                fmt_buf_s[i] = {1'b0, bcd_pad_s[4*i +: 4]};
            end else if (neg_r && (3'(i) == msd_s + 3'd1)) begin
                fmt_buf_s[i] = CODE_MINUS;
            end else begin
                fmt_buf_s[i] = CODE_BLANK;
            end
        end
    end

    // Next display buffer: a write in the FMT cycle supersedes the pending result.
    always_comb begin
        if (reset) begin
            buf_next_s   = RESET_BUF;
            shown_next_s = 16'd0;
        end else if (out_we && !dec_mode) begin
            buf_next_s   = hex_buf_s;
            shown_next_s = out_data;
        end else if ((state_r == FMT) && !out_we) begin
            buf_next_s   = fmt_buf_s;
            shown_next_s = pend_value_r;
        end else begin
            buf_next_s   = digit_buf_r;
            shown_next_s = shown_r;
        end
    end

    // Next scan position.
    always_comb begin
        cnt_wrap_s = (cnt_r >= SCAN_LAST);
        if (reset) begin
            idx_next_s = 3'd0;
        end else if (cnt_wrap_s) begin
            idx_next_s = idx_r + 3'd1;
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Display buffer and scan registers; segment drive follows the next buffer state.
    always_ff @(posedge clk) begin
        digit_buf_r <= buf_next_s;
        shown_r     <= shown_next_s;
        idx_r       <= idx_next_s;
        an_n_r      <= ~(8'd1 << idx_next_s);
        seg_n_r     <= glyph(buf_next_s[idx_next_s]);
        if (reset) begin
            cnt_r <= 16'd0;
        end else if (cnt_wrap_s) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Conversion FSM: any write restarts or aborts whatever conversion is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            step_r       <= 4'd0;
            mag_r        <= 16'd0;
            bcd_r        <= 20'd0;
            neg_r        <= 1'b0;
            pend_value_r <= 16'd0;
        end else if (out_we) begin
            if (dec_mode) begin
                state_r      <= CONV;
                busy_r       <= 1'b1;
                step_r       <= 4'd0;
                mag_r        <= in_mag_s;
                bcd_r        <= 20'd0;
                neg_r        <= out_data[15];
                pend_value_r <= out_data;
            end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                end
                CONV: begin
                    bcd_r  <= {bcd_adj_s[18:0], mag_r[15]};
                    mag_r  <= {mag_r[14:0], 1'b0};
                    step_r <= step_r + 4'd1;
                    if (step_r == 4'd15) begin
                        state_r <= FMT;
                    end else begin
                        state_r <= CONV;
                    end
                end
                FMT: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign shown_value = shown_r;
    assign seg_n       = seg_n_r;
    assign an_n        = an_n_r;

endmodule

// File: doc/out_display.md
Name: out_display

Overview:
Output-port peripheral for the SIMPLE CPU. It is the write-side counterpart of the dipswitch input path: it captures the 16-bit value of an OUT instruction and shows it on an 8-digit multiplexed 7-segment display. The value is shown either as raw hex or as signed decimal. Signed-decimal conversion is a sequential double-dabble engine, so a busy flag is provided. The block sits on the CPU writeback path next to the register file.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances; legal range 2..65535.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
out_we  input  1  write strobe from the OUT instruction; sampled every rising edge
out_data  input  16  value to display (two's complement)
dec_mode  input  1  sampled with out_we: 0 = hex, 1 = signed decimal
busy  output  1  decimal conversion in progress
shown_value  output  16  value whose glyphs are currently in the display buffer
seg_n  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp is always 1
an_n  output  8  active-low one-hot digit enable; digit 0 is the rightmost

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high. All state is registered.
- Reset values:
  - busy=0, shown_value=0.
  - Buffer: digit0='0', digits 1-7 blank.
  - Scan counter=0, digit index=0.
  - an_n=8'hFE, seg_n=8'hC0.
- Glyph encoding (seg_n):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - blank=FF, minus=BF
- Hex write (out_we=1, dec_mode=0) at edge T:
  - At edge T, digits 0-3 take nibbles [3:0]..[15:12], leading zeros kept. Digits 4-7 go blank.
  - At edge T, shown_value takes out_data. busy stays 0.
  - If a decimal conversion is running, it is aborted and busy falls at edge T.
- Decimal write (out_we=1, dec_mode=1) at edge T:
  - FSM states: IDLE -> CONV (16 cycles, one double-dabble shift per cycle) -> FMT (1 cycle) -> IDLE.
  - busy=1 from edge T through the FMT cycle, i.e. 17 cycles.
  - Magnitude is computed as a 16-bit unsigned value; 0x8000 gives magnitude 32768.
  - BCD result is 5 digits.
  - FMT blanks leading zeros; digit0 is always shown, so 0 displays as "0".
  - For negative values, minus is placed one digit left of the most significant shown digit. Unused digits are blank.
  - At the edge leaving FMT: the buffer and shown_value update, and busy falls, all on the same edge.
  - Until then, the previous buffer and shown_value stay displayed unchanged.
- Write while busy: last write wins. A decimal write restarts the conversion at CONV step 0 with the new value, and busy stays high for 17 cycles from the new write. The old conversion result is discarded and never displayed.
- Scan:
  - The counter runs 0..SCAN_DIV-1 and wraps. On a wrap the digit index increments mod 8 (7 -> 0).
  - an_n = ~(1<<idx) and seg_n = glyph(buffer[idx]) are registered and change on the same edge as the index.
  - Scanning continues during busy and is never reset by writes.
- Reset mid-operation: reset during CONV or FMT applies all reset values on that edge, and any pending result is lost. reset has priority over out_we on the same edge.

Test Plan:
1. SCAN_DIV=4, reset then idle → an_n=FE for 4 cycles, then FD, FB … 7F, back to FE after 32 cycles. seg_n=C0 while digit0 is enabled, FF otherwise.
2. Hex write 0xBEEF → next cycle shown_value=BEEF and busy=0. Digit0..3 seg_n = 8E, 86, 86, 83; digits 4-7 = FF.
3. Decimal write 0x8000 → busy high exactly 17 cycles, shown_value still 0 during busy. Afterwards shown_value=8000 and digits 0..7 = 80, 82, F8, A4, B0, BF, FF, FF (shows "-32768").
4. Decimal writes 0x0000 and 0xFFFF → "0": digit0=C0, rest FF. "-1": digit0=F9, digit1=BF, rest FF.
5. Decimal write 12345, then decimal write 7 on the 5th busy cycle → busy stays high continuously until 17 cycles after the second write. The display never shows 12345; final digit0=F8, others FF.
6. Decimal write 0x1234, reset asserted on the 8th busy cycle → next cycle busy=0 and shown_value=0. Buffer shows only '0'; no update follows.
